// File: rtl/hack_pkg.sv
// Shared definitions for the Hack program loader slice.
// Contents: word/ROM geometry constants and the loader state encoding.
package hack_pkg;

    localparam int WORD_W     = 16;
    localparam int ROM_ADDR_W = 15;
    localparam int ROM_DEPTH  = 32768;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LOAD = 3'd1,
        LD_HOLD = 3'd2,
        LD_RUN  = 3'd3,
        LD_ERR  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/hack_reset_stretch.sv
// Loadable down-counter that times the CPU reset dwell after the last ROM write.
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   trigger      - loads the counter with RST_HOLD
//   busy         - counter non-zero
//   expired      - counter has reached zero
// The counter is loaded on the same edge that produces the final ROM write, so
// the write cycle itself sees RST_HOLD; the following RST_HOLD cycles count down
// to zero, and the cycle showing zero is the last reset-held cycle.
module hack_reset_stretch #(
    parameter int RST_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic busy,
    output logic expired
);
    localparam int CNT_W = $clog2(RST_HOLD + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (trigger) begin
            cnt <= CNT_W'(RST_HOLD);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy    = (cnt != '0);
    assign expired = (cnt == '0);

endmodule

// File: rtl/hack_prog_loader.sv
// Boot-time loader for the Hack instruction ROM.
// Accepts program words from a valid/ready stream and writes them to the ROM
// sequentially from address 0, holding the CPU in reset until loading is over.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   start               - 1-cycle pulse, begin a new load (IDLE/RUN/ERR only)
//   in_valid/in_ready   - stream handshake; in_data/in_last qualified by it
//   rom_we/addr/wdata   - registered ROM write port
//   cpu_reset, done     - CPU reset (active high) and load-complete flag
//   overflow            - more than DEPTH words offered; cleared by start
//   word_count/checksum - words accepted and their 16-bit sum
//   state, hold_busy    - debug view of the FSM and the reset dwell counter
// Handshake: a word transfers on every rising edge where in_valid and in_ready
// are both high; in_ready depends only on state, never on in_valid.
module hack_prog_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W   = ROM_ADDR_W,
    parameter int DEPTH    = ROM_DEPTH,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [WORD_W-1:0] checksum,
    output ld_state_e         state,
    output logic              hold_busy
);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    ld_state_e state_q, state_d;
    logic      accept;
    logic      restart;
    logic      hold_expired;

    assign accept  = in_valid & in_ready;
    // start only has an effect where the FSM is waiting for one
    assign restart = start & ((state_q == LD_IDLE) || (state_q == LD_RUN) ||
                              (state_q == LD_ERR));
    assign state   = state_q;

    hack_reset_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_stretch (
        .clk     (clk),
        .reset   (reset),
        .trigger (accept & in_last),
        .busy    (hold_busy),
        .expired (hold_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        overflow  = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (start) state_d = LD_LOAD;
            end
            LD_LOAD: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_d = LD_HOLD;
                end else if (accept && (word_count == LAST_IDX)) begin
                    // ROM is now full and the stream still has more to say
                    state_d = LD_ERR;
                end
            end
            LD_HOLD: begin
                if (hold_expired) state_d = LD_RUN;
            end
            LD_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) state_d = LD_LOAD;
            end
            LD_ERR: begin
                overflow = 1'b1;
                if (start) state_d = LD_LOAD;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // Write port and status counters. Address/data hold when no word arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            rom_we <= 1'b0;
            if (restart) begin
                word_count <= '0;
                checksum   <= '0;
            end else if (accept) begin
                rom_we     <= 1'b1;
                rom_addr   <= word_count[ADDR_W-1:0];
                rom_wdata  <= in_data;
                word_count <= word_count + (ADDR_W+1)'(1);
                checksum   <= checksum + in_data;
            end
        end
    end

endmodule

// File: tb/tb_hack_prog_loader.sv
// Bench for hack_prog_loader: a full-size instance plus a DEPTH=8 instance for
// the overflow case, sharing one stimulus stream. Writes are scored against a
// queue of {addr, data} filled by the stream driver.
module tb_hack_prog_loader;
    import hack_pkg::*;

    localparam int RST_HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic in_last = 1'b0;
    logic sel = 1'b0;

    logic in_ready, rom_we, cpu_reset, done, overflow, hold_busy;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata, checksum;
    logic [15:0] word_count;
    ld_state_e   state;

    logic o_in_ready, o_rom_we, o_cpu_reset, o_done, o_overflow, o_hold_busy;
    logic [2:0]  o_rom_addr;
    logic [15:0] o_rom_wdata, o_checksum;
    logic [3:0]  o_word_count;
    ld_state_e   o_state;

    logic m_ready, m_rom_we, m_cpu_reset, m_done, m_overflow, m_busy;
    logic [14:0] m_rom_addr;
    logic [15:0] m_rom_wdata, m_checksum, m_word_count;
    ld_state_e   m_state;

    int checks = 0;
    int failures = 0;
    int exp_addr = 0;
    int model_cnt = 0;
    logic [15:0] model_sum = '0;
    logic [30:0] exp_q[$];

    hack_prog_loader #(.ADDR_W(15), .DEPTH(32768), .RST_HOLD(RST_HOLD)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .done(done), .overflow(overflow),
        .word_count(word_count), .checksum(checksum),
        .state(state), .hold_busy(hold_busy)
    );

    hack_prog_loader #(.ADDR_W(3), .DEPTH(8), .RST_HOLD(RST_HOLD)) u_ovf (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(o_in_ready), .in_data(in_data), .in_last(in_last),
        .rom_we(o_rom_we), .rom_addr(o_rom_addr), .rom_wdata(o_rom_wdata),
        .cpu_reset(o_cpu_reset), .done(o_done), .overflow(o_overflow),
        .word_count(o_word_count), .checksum(o_checksum),
        .state(o_state), .hold_busy(o_hold_busy)
    );

    assign m_ready      = sel ? o_in_ready : in_ready;
    assign m_rom_we     = sel ? o_rom_we : rom_we;
    assign m_rom_addr   = sel ? {12'b0, o_rom_addr} : rom_addr;
    assign m_rom_wdata  = sel ? o_rom_wdata : rom_wdata;
    assign m_cpu_reset  = sel ? o_cpu_reset : cpu_reset;
    assign m_done       = sel ? o_done : done;
    assign m_overflow   = sel ? o_overflow : overflow;
    assign m_busy       = sel ? o_hold_busy : hold_busy;
    assign m_word_count = sel ? {12'b0, o_word_count} : word_count;
    assign m_checksum   = sel ? o_checksum : checksum;
    assign m_state      = sel ? o_state : state;

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_addr  = 0;
        model_cnt = 0;
        model_sum = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic pulse_start(input bit clears);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (clears) model_clear();
    endtask

    // Offers one word and returns at the cycle showing its ROM write.
    task automatic send_word(input logic [15:0] d, input logic l);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (m_ready) begin
                exp_q.push_back({15'(exp_addr), d});
                exp_addr++;
                model_cnt++;
                model_sum += d;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called in the cycle of the last write.
    task automatic finish_hold();
        check("hold_state", m_state, LD_HOLD);
        check("hold_busy", m_busy, 1);
        for (int i = 0; i < RST_HOLD; i++) begin
            @(posedge clk);
            #1;
            check("hold_cpu_reset", m_cpu_reset, 1);
            check("hold_done", m_done, 0);
        end
        @(posedge clk);
        #1;
        check("run_cpu_reset", m_cpu_reset, 0);
        check("run_done", m_done, 1);
        check("run_count", m_word_count, 32'(model_cnt));
        check("run_checksum", m_checksum, model_sum);
    endtask

    task automatic check_drained();
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (m_rom_we) begin
            if (exp_q.size() == 0) begin
                check("rom_we_unexpected", 1, 0);
            end else begin
                check("rom_write", {1'b0, m_rom_addr, m_rom_wdata}, {1'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_rom_we", rom_we, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_wdata", rom_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_word_count", word_count, 0);
        check("rst_checksum", checksum, 0);
        check("rst_state", state, LD_IDLE);
        reset = 1'b1;
        model_clear();

        // basic 3-word load
        pulse_start(1);
        check("t1_in_ready", in_ready, 1);
        send_word(16'h0002, 0);
        send_word(16'hEC10, 0);
        send_word(16'h0000, 1);
        check("t1_ready_in_hold", in_ready, 0);
        finish_hold();
        check("t1_count", word_count, 3);
        check("t1_checksum", checksum, 16'hEC12);
        check_drained();

        // reload while running, 1-word program
        pulse_start(1);
        check("t5_cpu_reset", cpu_reset, 1);
        check("t5_done", done, 0);
        check("t5_count_clr", word_count, 0);
        check("t5_sum_clr", checksum, 0);
        send_word(16'h7FFF, 1);
        finish_hold();
        check("t5_count", word_count, 1);
        check("t5_checksum", checksum, 16'h7FFF);
        check_drained();

        // start during LOAD is ignored: address keeps counting
        pulse_start(1);
        send_word(16'h1234, 0);
        pulse_start(0);
        check("t6_state_load", state, LD_LOAD);
        check("t6_count_kept", word_count, 1);
        send_word(16'h4321, 1);
        finish_hold();
        check_drained();

        // start coincident with reset: reset wins
        start = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        model_clear();
        check("t6_rst_state", state, LD_IDLE);
        check("t6_rst_cpu_reset", cpu_reset, 1);
        check("t6_rst_done", done, 0);
        @(posedge clk);
        #1;
        check("t6_rst_still_idle", state, LD_IDLE);

        // backpressure with random gaps
        pulse_start(1);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(16'($urandom_range(0, 65535)), (i == 9));
        end
        finish_hold();
        check("t2_count", word_count, 10);
        check_drained();

        // reset mid-load after 2 of 5 words
        pulse_start(1);
        send_word(16'h0A0A, 0);
        send_word(16'h0B0B, 0);
        in_valid = 1'b1;
        in_data  = 16'h0C0C;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        check("t4_cpu_reset", cpu_reset, 1);
        check("t4_count", word_count, 0);
        check("t4_in_ready", in_ready, 0);
        check("t4_state", state, LD_IDLE);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t4_count_after", word_count, 0);
        check_drained();

        // overflow on the DEPTH=8 instance
        sel = 1'b1;
        do_reset(2);
        pulse_start(1);
        for (int i = 0; i < 8; i++) send_word(16'(i * 16'h0111 + 1), 0);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        check("t3_in_ready", m_ready, 0);
        check("t3_overflow", m_overflow, 1);
        check("t3_cpu_reset", m_cpu_reset, 1);
        check("t3_state", m_state, LD_ERR);
        check("t3_count", m_word_count, 8);
        in_valid = 1'b0;
        pulse_start(1);
        check("t3_overflow_clr", m_overflow, 0);
        check("t3_ready_again", m_ready, 1);
        check("t3_count_clr", m_word_count, 0);
        send_word(16'hBEEF, 1);
        finish_hold();
        check_drained();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
